// File: rtl/fadd_result_writeback.sv
// fadd_result_writeback
//   Queues float_adder_32 results (data, NaN/overflow flags, destination VGPR)
//   in a small circular FIFO and drains them to the VGPR write port over a
//   valid/ready handshake. Keeps sticky NaN/overflow status bits for software,
//   and can optionally replace NaN results with a canonical quiet NaN.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake (push when both high)
//   in_result         adder result
//   in_nan, in_ovf    adder exception flags
//   in_vdst           destination VGPR index
//   wb_valid/wb_ready VGPR write handshake (pop when both high)
//   wb_data, wb_vdst  head entry (zero when the queue is empty)
//   wb_exc            head flags {ovf, nan}
//   flush             drop every queued entry
//   status_clr        clear the sticky status bits
//   status_nan/ovf    sticky exception status
//   count             number of occupied entries
module fadd_result_writeback #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 4,
  parameter int CANON_NAN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_nan,
  input  logic                       in_ovf,
  input  logic [TAG_W-1:0]           in_vdst,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [TAG_W-1:0]           wb_vdst,
  output logic [1:0]                 wb_exc,
  input  logic                       flush,
  input  logic                       status_clr,
  output logic                       status_nan,
  output logic                       status_ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_vdst [DEPTH];
  logic [1:0]        mem_exc  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] store_data;

  // in_ready looks only at count, so a full queue refuses a push even when
  // the head is being popped in the same cycle.
  always_comb begin
    in_ready = (count != CNT_W'(DEPTH));
    wb_valid = (count != '0);
    push     = in_valid && in_ready;
    pop      = wb_valid && wb_ready;
  end

  always_comb begin
    store_data = in_result;
    if (CANON_NAN != 0 && in_nan)
      store_data = QNAN;
  end

  always_comb begin
    wb_data = '0;
    wb_vdst = '0;
    wb_exc  = '0;
    if (wb_valid) begin
      wb_data = mem_data[rd_ptr];
      wb_vdst = mem_vdst[rd_ptr];
      wb_exc  = mem_exc[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      status_nan <= 1'b0;
      status_ovf <= 1'b0;
    end else begin
      // Sticky bits still see a push accepted in a flush cycle; set beats clear.
      status_nan <= (status_nan && !status_clr) || (push && in_nan);
      status_ovf <= (status_ovf && !status_clr) || (push && in_ovf);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem_data[wr_ptr] <= store_data;
          mem_vdst[wr_ptr] <= in_vdst;
          mem_exc[wr_ptr]  <= {in_ovf, in_nan};
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fadd_result_writeback.sv
module tb_fadd_result_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_nan;
  logic        in_ovf;
  logic [7:0]  in_vdst;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [7:0]  wb_vdst;
  logic [1:0]  wb_exc;
  logic        flush;
  logic        status_clr;
  logic        status_nan;
  logic        status_ovf;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  vdst;
    logic [1:0]  exc;
  } ent_t;

  ent_t q[$];
  logic m_nan = 1'b0;
  logic m_ovf = 1'b0;

  fadd_result_writeback #(
    .DATA_W(32),
    .TAG_W(8),
    .DEPTH(DEPTH),
    .CANON_NAN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_nan(in_nan), .in_ovf(in_ovf), .in_vdst(in_vdst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_vdst(wb_vdst), .wb_exc(wb_exc),
    .flush(flush), .status_clr(status_clr),
    .status_nan(status_nan), .status_ovf(status_ovf), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus two sticky bits, advanced once per edge.
  task automatic cycle();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = wb_ready && (q.size() > 0);
    e.data  = in_nan ? 32'h7FC0_0000 : in_result;
    e.vdst  = in_vdst;
    e.exc   = {in_ovf, in_nan};
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_nan = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_nan = (m_nan && !status_clr) || (do_push && in_nan);
      m_ovf = (m_ovf && !status_clr) || (do_push && in_ovf);
      if (flush) q.delete();
      else begin
        if (do_pop) q.delete(0);
        if (do_push) q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_data();
    return (q.size() > 0) ? q[0].data : 32'h0;
  endfunction

  function automatic logic [7:0] exp_vdst();
    return (q.size() > 0) ? q[0].vdst : 8'h0;
  endfunction

  function automatic logic [1:0] exp_exc();
    return (q.size() > 0) ? q[0].exc : 2'b00;
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; in_result = '0; in_nan = 0; in_ovf = 0;
    in_vdst = '0; wb_ready = 0; flush = 0; status_clr = 0;
  endtask

  task automatic drive_push(input logic [31:0] d, input logic [7:0] v,
                            input logic n, input logic o);
    in_valid = 1; in_result = d; in_vdst = v; in_nan = n; in_ovf = o;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    checks += 6;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    if (wb_data !== 32'h0 || wb_vdst !== 8'h0 || wb_exc !== 2'b00) begin
      errors++; $display("FAIL reset_wb_fields: got %h/%h/%b want 0/0/0", wb_data, wb_vdst, wb_exc);
    end
    if (status_nan !== 1'b0) begin errors++; $display("FAIL reset_status_nan: got %b want 0", status_nan); end
    if (status_ovf !== 1'b0) begin errors++; $display("FAIL reset_status_ovf: got %b want 0", status_ovf); end
  endtask

  task automatic test_single_push();
    idle();
    drive_push(32'h4040_0000, 8'h05, 0, 0);
    cycle();
    idle();
    checks += 3;
    if (wb_valid !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL single_valid_count: got %b/%0d want 1/1", wb_valid, count);
    end
    if (wb_data !== 32'h4040_0000) begin errors++; $display("FAIL single_data: got %h want 40400000", wb_data); end
    if (wb_vdst !== 8'h05 || wb_exc !== 2'b00) begin
      errors++; $display("FAIL single_vdst_exc: got %h/%b want 05/00", wb_vdst, wb_exc);
    end
    wb_ready = 1;
    cycle();
    idle();
    checks++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: got count %0d valid %b want 0/0", count, wb_valid);
    end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] vals [4];
    vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
    vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_push(vals[i], 8'(8'h10 + i), 0, 0);
      cycle();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got count %0d in_ready %b want 4/0", count, in_ready);
    end
    drive_push(32'h40A0_0000, 8'h99, 0, 0);
    cycle();
    idle();
    checks++;
    if (count !== 3'd4 || wb_data !== 32'h3F80_0000) begin
      errors++; $display("FAIL fill_fifth_ignored: got count %0d head %h want 4/3f800000", count, wb_data);
    end
    for (int round = 0; round < 2; round++) begin
      wb_ready = 1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wb_data !== vals[i] || wb_vdst !== 8'(8'h10 + i + 4 * round)) begin
          errors++;
          $display("FAIL fill_drain_order: round %0d idx %0d got %h/%h want %h/%h",
                   round, i, wb_data, wb_vdst, vals[i], 8'(8'h10 + i + 4 * round));
        end
        cycle();
      end
      idle();
      checks++;
      if (count !== 3'd0 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL fill_empty: got count %0d valid %b want 0/0", count, wb_valid);
      end
      if (round == 0) begin
        for (int i = 0; i < 4; i++) begin
          drive_push(vals[i], 8'(8'h14 + i), 0, 0);
          cycle();
        end
        idle();
      end
    end
  endtask

  task automatic test_nan_canon();
    idle();
    status_clr = 1;
    cycle();
    idle();
    drive_push(32'h7FC0_0001, 8'h21, 1, 0);
    cycle();
    idle();
    checks += 2;
    if (wb_data !== 32'h7FC0_0000 || wb_exc !== 2'b01) begin
      errors++; $display("FAIL nan_canon: got %h/%b want 7fc00000/01", wb_data, wb_exc);
    end
    if (status_nan !== 1'b1) begin errors++; $display("FAIL nan_sticky: got %b want 1", status_nan); end
    drive_push(32'hFFC1_2345, 8'h22, 1, 0);
    status_clr = 1;
    cycle();
    idle();
    checks += 2;
    if (status_nan !== 1'b1) begin errors++; $display("FAIL nan_set_beats_clr: got %b want 1", status_nan); end
    if (count !== 3'd2) begin errors++; $display("FAIL nan_count: got %0d want 2", count); end
    wb_ready = 1;
    cycle();
    cycle();
    idle();
  endtask

  task automatic test_overflow();
    idle();
    drive_push(32'h7F80_0000, 8'h31, 0, 1);
    cycle();
    idle();
    checks += 2;
    if (wb_data !== 32'h7F80_0000 || wb_exc !== 2'b10) begin
      errors++; $display("FAIL ovf_entry: got %h/%b want 7f800000/10", wb_data, wb_exc);
    end
    if (status_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", status_ovf); end
    status_clr = 1;
    wb_ready = 1;
    cycle();
    idle();
    checks++;
    if (status_ovf !== 1'b0 || status_nan !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got ovf %b nan %b want 0/0", status_ovf, status_nan);
    end
    drive_push(32'hFF80_0000, 8'h32, 0, 0);
    cycle();
    idle();
    checks++;
    if (wb_data !== 32'hFF80_0000 || wb_exc !== 2'b00) begin
      errors++; $display("FAIL neg_inf_passthru: got %h/%b want ff800000/00", wb_data, wb_exc);
    end
    wb_ready = 1;
    cycle();
    idle();
  endtask

  task automatic test_streaming();
    idle();
    drive_push(32'h1000_0000, 8'd0, 0, 0);
    cycle();
    drive_push(32'h1000_0001, 8'd1, 0, 0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h1000_0000 + 32'(i + 2), 8'(i + 2), 0, 0);
      wb_ready = 1;
      checks++;
      if (count !== 3'd2 || wb_vdst !== 8'(i)) begin
        errors++; $display("FAIL stream_step: cycle %0d got count %0d vdst %0d want 2/%0d", i, count, wb_vdst, i);
      end
      cycle();
    end
    idle();
    checks++;
    if (count !== 3'd2 || wb_vdst !== 8'd10) begin
      errors++; $display("FAIL stream_end: got count %0d vdst %0d want 2/10", count, wb_vdst);
    end
    wb_ready = 1;
    cycle();
    cycle();
    idle();
  endtask

  task automatic test_flush_reset();
    idle();
    status_clr = 1;
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h4100_0000, 8'(8'h40 + i), 0, 0);
      cycle();
    end
    idle();
    drive_push(32'h7FC0_0005, 8'h50, 1, 0);
    flush = 1;
    cycle();
    idle();
    checks += 2;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got count %0d valid %b want 0/0", count, wb_valid);
    end
    if (status_nan !== 1'b1) begin errors++; $display("FAIL flush_sticky: got %b want 1", status_nan); end
    drive_push(32'h7F80_0000, 8'h60, 0, 1);
    cycle();
    drive_push(32'h4200_0000, 8'h61, 0, 0);
    cycle();
    drive_push(32'h7FC0_0000, 8'h62, 1, 1);
    rst = 1;
    cycle();
    idle();
    checks += 2;
    if (count !== 3'd0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_queue: got count %0d in_ready %b valid %b want 0/1/0", count, in_ready, wb_valid);
    end
    if (status_nan !== 1'b0 || status_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_mid_status: got nan %b ovf %b want 0/0", status_nan, status_ovf);
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      // Upstream must hold its payload while a push is stalled.
      if (!(in_valid && !in_ready)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_result = $urandom();
        in_nan    = ($urandom_range(0, 5) == 0);
        in_ovf    = ($urandom_range(0, 5) == 0);
        in_vdst   = 8'($urandom());
      end
      wb_ready   = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      status_clr = ($urandom_range(0, 15) == 0);
      cycle();
      checks++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) || wb_valid !== (q.size() > 0) ||
          wb_data !== exp_data() || wb_vdst !== exp_vdst() || wb_exc !== exp_exc() ||
          status_nan !== m_nan || status_ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_step %0d: got cnt %0d rdy %b vld %b d %h v %h e %b sn %b so %b want cnt %0d d %h v %h e %b sn %b so %b",
                 i, count, in_ready, wb_valid, wb_data, wb_vdst, wb_exc, status_nan, status_ovf,
                 q.size(), exp_data(), exp_vdst(), exp_exc(), m_nan, m_ovf);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_push();
    test_fill_wrap();
    test_nan_canon();
    test_overflow();
    test_streaming();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
